mci_axi_mgr_bridge: RTL and testbench
=====================================

// Module: mci_axi_mgr_bridge
// PURPOSE
//  Single-outstanding AXI4 manager: turns a simplex cif-style request (dv/hold) into one AXI4 single-beat
//  read or write and returns rdata/error. This is the initiator that drives the AXI subordinate port of
//  MCI (or any AXI sub) from MCI-internal logic. One transaction in flight at a time; no bursts.
// PARAMETERS
//  AW  32  AXI/request address width
//  DW  32  data width (32 or 64); AxSIZE = log2(DW/8)
//  UW  32  AxUSER width
//  IW  8   AxID width
//  ID  0   constant ARID/AWID driven on every transaction
// PORTS
//  clk             in   1      clock
//  rst             in   1      async active-high reset
//  req_dv          in   1      request valid; accepted when req_dv && !req_hold
//  req_write       in   1      1=write, 0=read
//  req_addr        in   AW     byte address, must be DW/8-aligned
//  req_wdata       in   DW     write data
//  req_wstrb       in   DW/8   write byte strobes
//  req_user        in   UW     driven on AxUSER
//  req_hold        out  1      busy; new requests not accepted
//  rsp_valid       out  1      1-cycle pulse: transaction complete
//  rsp_rdata       out  DW     read data (0 on write or error), valid with rsp_valid
//  rsp_error       out  1      error status, valid with rsp_valid
//  m_axi_aw{valid,addr,id,user,len,size,burst}  out  1/AW/IW/UW/8/3/2  write address channel
//  m_axi_awready   in   1
//  m_axi_w{valid,data,strb,last}  out  1/DW/DW/8/1  write data channel
//  m_axi_wready    in   1
//  m_axi_b{valid,resp,id}  in  1/2/IW  write response; m_axi_bready out 1
//  m_axi_ar{valid,addr,id,user,len,size,burst}  out  1/AW/IW/UW/8/3/2  read address channel
//  m_axi_arready   in   1
//  m_axi_r{valid,data,resp,id,last}  in  1/DW/2/IW/1  read data; m_axi_rready out 1
// BEHAVIOUR
//  Reset: state IDLE; all *valid, bready, rready, req_hold, rsp_valid, rsp_error = 0; rsp_rdata = 0.
//  Constants: AxLEN=0, AxSIZE=log2(DW/8), AxBURST=2'b01, WLAST=1, AxID=ID. Addr/data/user registered at accept.
//  FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
//  IDLE: req_hold=0. On accept: misaligned addr -> DONE with error=1, no AXI traffic;
//   write -> WR_REQ (awvalid=wvalid=1 next cycle); read -> RD_REQ (arvalid=1 next cycle).
//  req_hold=1 in every state except IDLE, combinationally from state.
//  WR_REQ: awvalid/wvalid each held with stable payload until own handshake, then deasserted independently;
//   W may complete before, with, or after AW. Both done -> WR_RESP.
//  WR_RESP: bready=1; on bvalid -> DONE, error = bresp!=2'b00 || bid!=ID.
//  RD_REQ: arvalid held until arready -> RD_DATA. RD_DATA: rready=1; on rvalid -> DONE,
//   error = rresp!=2'b00 || rid!=ID || !rlast; rsp_rdata = error ? 0 : rdata.
//  DONE: rsp_valid=1 for exactly 1 cycle -> IDLE. Next request acceptable the cycle after DONE.
//  Latency (all readys high): accept at T, AxVALID at T+1, B/R at T+2 earliest, rsp_valid at T+3.
//  Valids never deassert before handshake except on rst. Stray bvalid/rvalid outside WR_RESP/RD_DATA:
//   ready stays 0 (not consumed). req_dv while hold=1 ignored, no queuing.
//  rst mid-transaction: immediately IDLE, all outputs to reset values; pending AXI response is lost.
// TESTING
//  Write 0x1000/0xDEADBEEF/strb 0xF, readys high, bresp=0 -> awvalid&wvalid at T+1, rsp_valid T+3, error=0.
//  Read 0x2000, arready low 5 cycles, rdata=0x12345678 -> araddr stable 6 cycles, rsp_rdata=0x12345678.
//  Write with wready 3 cycles before awready -> wvalid drops after W hs, awvalid held; exactly one bready hs.
//  bresp=2'b10 -> rsp_error=1; read rresp=2'b11 -> error=1, rsp_rdata=0; rid!=ID -> error=1.
//  Misaligned addr 0x1002 -> no AxVALID ever, rsp_valid T+1 with error=1; req_dv during hold -> ignored.
//  rst asserted in RD_DATA -> arvalid/rready/req_hold=0 same cycle; post-reset read completes normally.

Source files
------------

// File: rtl/mci_axi_mgr_bridge.sv
// Single-outstanding AXI4 manager: converts one dv/hold request into a single-beat
// AXI4 read or write and returns rdata/error with a one-cycle rsp_valid pulse.
module mci_axi_mgr_bridge #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int UW = 32,
  parameter int IW = 8,
  parameter int ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_dv,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  input  logic [UW-1:0]   req_user,
  output logic            req_hold,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_error,
  output logic            m_axi_awvalid,
  output logic [AW-1:0]   m_axi_awaddr,
  output logic [IW-1:0]   m_axi_awid,
  output logic [UW-1:0]   m_axi_awuser,
  output logic [7:0]      m_axi_awlen,
  output logic [2:0]      m_axi_awsize,
  output logic [1:0]      m_axi_awburst,
  input  logic            m_axi_awready,
  output logic            m_axi_wvalid,
  output logic [DW-1:0]   m_axi_wdata,
  output logic [DW/8-1:0] m_axi_wstrb,
  output logic            m_axi_wlast,
  input  logic            m_axi_wready,
  input  logic            m_axi_bvalid,
  input  logic [1:0]      m_axi_bresp,
  input  logic [IW-1:0]   m_axi_bid,
  output logic            m_axi_bready,
  output logic            m_axi_arvalid,
  output logic [AW-1:0]   m_axi_araddr,
  output logic [IW-1:0]   m_axi_arid,
  output logic [UW-1:0]   m_axi_aruser,
  output logic [7:0]      m_axi_arlen,
  output logic [2:0]      m_axi_arsize,
  output logic [1:0]      m_axi_arburst,
  input  logic            m_axi_arready,
  input  logic            m_axi_rvalid,
  input  logic [DW-1:0]   m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic [IW-1:0]   m_axi_rid,
  input  logic            m_axi_rlast,
  output logic            m_axi_rready
);

  localparam int SZ = $clog2(DW/8);
  localparam logic [IW-1:0] ID_V = IW'(ID);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_e;

  state_e            state_q, state_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic              bready_q, bready_d, rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic [UW-1:0]     user_q, user_d;
  logic              misaligned;
  logic              r_err;

  assign misaligned = |req_addr[SZ-1:0];
  assign r_err      = (m_axi_rresp != 2'b00) || (m_axi_rid != ID_V) || !m_axi_rlast;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    user_d      = user_q;
    case (state_q)
      IDLE: if (req_dv) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
        user_d  = req_user;
        if (misaligned) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end else if (req_write) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = RD_REQ;
          arvalid_d = 1'b1;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; a cleared valid means that channel is done.
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (m_axi_bvalid) begin
        state_d     = DONE;
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_error_d = (m_axi_bresp != 2'b00) || (m_axi_bid != ID_V);
        rsp_rdata_d = '0;
      end
      RD_REQ: if (m_axi_arready) begin
        state_d   = RD_DATA;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      RD_DATA: if (m_axi_rvalid) begin
        state_d     = DONE;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_error_d = r_err;
        rsp_rdata_d = r_err ? '0 : m_axi_rdata;
      end
      DONE: begin
        state_d     = IDLE;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      user_q      <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      user_q      <= user_d;
    end
  end

  assign req_hold      = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_rdata     = rsp_rdata_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = ID_V;
  assign m_axi_awuser  = user_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = ID_V;
  assign m_axi_aruser  = user_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_mci_axi_mgr_bridge.sv
// Scoreboard bench for mci_axi_mgr_bridge: expected responses are queued at issue
// and popped by a monitor whenever rsp_valid pulses.
module tb_mci_axi_mgr_bridge;
  localparam int AW = 32, DW = 32, UW = 32, IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_dv = 0, req_write = 0, req_hold;
  logic [AW-1:0] req_addr = 0;
  logic [DW-1:0] req_wdata = 0;
  logic [3:0]    req_wstrb = 0;
  logic [UW-1:0] req_user = 0;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          awvalid, awready = 0, wvalid, wready = 0, wlast;
  logic [AW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid, bid = 0, rid = 0;
  logic [UW-1:0] awuser, aruser;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp = 0, rresp = 0;
  logic [DW-1:0] wdata, rdata = 0;
  logic [3:0]    wstrb;
  logic          bvalid = 0, bready, arvalid, arready = 0;
  logic          rvalid = 0, rlast = 1, rready;

  mci_axi_mgr_bridge dut (
    .clk(clk), .rst(rst),
    .req_dv(req_dv), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_user(req_user), .req_hold(req_hold),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awid(awid), .m_axi_awuser(awuser),
    .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awready(awready),
    .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bid(bid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arid(arid), .m_axi_aruser(aruser),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arready(arready),
    .m_axi_rvalid(rvalid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rid(rid),
    .m_axi_rlast(rlast), .m_axi_rready(rready)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   b_hs     = 0;

  // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, expected no response", rsp_rdata, rsp_error);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if ({rsp_rdata, rsp_error} !== e) begin
          n_fail++;
          $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                   rsp_rdata, rsp_error, e.rdata, e.err);
        end
      end
    end
    if (!rst && bvalid && bready) b_hs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [DW-1:0] d, input logic e);
    sb.push_back(rsp_t'{rdata: d, err: e});
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_user  = a ^ 32'h5A5A_0000;
    req_dv    = 1'b1;
    tick();
    req_dv    = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, expected a response", cyc);
    end
  endtask

  task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_d, input logic exp_e, input int exp_lat);
    int cyc;
    n_checks++;
    if (req_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got req_hold=%b, expected 0", req_hold);
    end
    expect_rsp(exp_d, exp_e);
    issue(wr, a, d, 4'hF);
    wait_rsp(cyc);
    n_checks++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles after accept, expected %0d", cyc, exp_lat);
    end
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, req_hold, rsp_valid, rsp_error} !== 8'h00 ||
        rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_in: got ctl=%b rdata=%h, expected 0",
               {awvalid, wvalid, arvalid, bready, rready, req_hold, rsp_valid, rsp_error}, rsp_rdata);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, req_hold, rsp_valid} !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_out: got ctl=%b, expected 0",
               {awvalid, wvalid, arvalid, bready, rready, req_hold, rsp_valid});
    end
  endtask

  task automatic test_write_basic();
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00; bid = 0;
    expect_rsp('0, 1'b0);
    issue(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if ({awvalid, wvalid, bready, req_hold} !== 4'b1101) begin
      n_fail++;
      $display("FAIL wr_t1_valids: got aw/w/b/hold=%b, expected 1101", {awvalid, wvalid, bready, req_hold});
    end
    n_checks++;
    if (awaddr !== 32'h1000 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF || awuser !== 32'h5A5A_1000) begin
      n_fail++;
      $display("FAIL wr_payload: got addr=%h data=%h strb=%h user=%h, expected 1000 deadbeef f 5a5a1000",
               awaddr, wdata, wstrb, awuser);
    end
    n_checks++;
    if ({awlen, awsize, awburst, wlast, awid} !== {8'd0, 3'd2, 2'b01, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL wr_consts: got len=%h size=%h burst=%b last=%b id=%h, expected 0 2 01 1 0",
               awlen, awsize, awburst, wlast, awid);
    end
    tick();
    n_checks++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL wr_t2: got aw/w/b/rsp=%b, expected 0010", {awvalid, wvalid, bready, rsp_valid});
    end
    tick();
    n_checks++;
    if ({rsp_valid, req_hold, bready} !== 3'b110) begin
      n_fail++;
      $display("FAIL wr_t3: got rsp/hold/bready=%b, expected 110", {rsp_valid, req_hold, bready});
    end
    tick();
    n_checks++;
    if ({rsp_valid, req_hold} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_t4: got rsp/hold=%b, expected 00", {rsp_valid, req_hold});
    end
    bvalid = 0;
  endtask

  task automatic test_read_stall();
    int cyc;
    arready = 0; rvalid = 1; rdata = 32'h12345678; rresp = 0; rid = 0; rlast = 1;
    expect_rsp(32'h12345678, 1'b0);
    issue(1'b0, 32'h2000, '0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) arready = 1;
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h2000 || rready !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_stall_%0d: got arvalid=%b araddr=%h rready=%b, expected 1 2000 0",
                 i, arvalid, araddr, rready);
      end
      if (i < 5) tick();
    end
    wait_rsp(cyc);
    n_checks++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL rd_stall_lat: got %0d cycles after AR release, expected 2", cyc);
    end
    tick();
    rvalid = 0;
  endtask

  task automatic test_write_w_first();
    int cyc;
    int hs0;
    awready = 0; wready = 1; bvalid = 1; bresp = 0; bid = 0;
    hs0 = b_hs;
    expect_rsp('0, 1'b0);
    issue(1'b1, 32'h1100, 32'hA5A5_0F0F, 4'h3);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) awready = 1;
      n_checks++;
      if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h1100) begin
        n_fail++;
        $display("FAIL wfirst_%0d: got aw/w/b=%b addr=%h, expected 100 1100",
                 i, {awvalid, wvalid, bready}, awaddr);
      end
      if (i < 2) tick();
    end
    wait_rsp(cyc);
    tick();
    n_checks++;
    if (b_hs - hs0 != 1) begin
      n_fail++;
      $display("FAIL wfirst_bhs: got %0d B handshakes, expected 1", b_hs - hs0);
    end
    bvalid = 0; awready = 1;
  endtask

  task automatic test_errors();
    awready = 1; wready = 1; arready = 1; bvalid = 1; rvalid = 1; rlast = 1;
    bresp = 2'b10; bid = 0;
    do_txn(1'b1, 32'h1200, 32'h1, '0, 1'b1, 2);
    bresp = 2'b00; bid = 8'h3;
    do_txn(1'b1, 32'h1204, 32'h2, '0, 1'b1, 2);
    bid = 0;
    rresp = 2'b11; rdata = 32'hAAAA5555;
    do_txn(1'b0, 32'h1300, '0, '0, 1'b1, 2);
    rresp = 2'b00; rid = 8'h5;
    do_txn(1'b0, 32'h1304, '0, '0, 1'b1, 2);
    rid = 0; rlast = 0;
    do_txn(1'b0, 32'h1308, '0, '0, 1'b1, 2);
    rlast = 1;
    do_txn(1'b0, 32'h130C, '0, 32'hAAAA5555, 1'b0, 2);
    bvalid = 0; rvalid = 0;
  endtask

  task automatic test_misaligned();
    int cyc;
    expect_rsp('0, 1'b1);
    issue(1'b1, 32'h1002, 32'h77, 4'hF);
    n_checks++;
    if ({rsp_valid, awvalid, wvalid, arvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL misalign_t1: got rsp/aw/w/ar=%b, expected 1000", {rsp_valid, awvalid, wvalid, arvalid});
    end
    wait_rsp(cyc);
    tick();
    tick();
    n_checks++;
    if ({awvalid, wvalid, arvalid, req_hold} !== 4'b0000) begin
      n_fail++;
      $display("FAIL misalign_after: got aw/w/ar/hold=%b, expected 0000", {awvalid, wvalid, arvalid, req_hold});
    end
  endtask

  task automatic test_hold_ignore();
    int cyc;
    arready = 0; rvalid = 1; rdata = 32'h11112222; rresp = 0; rid = 0; rlast = 1;
    expect_rsp(32'h11112222, 1'b0);
    issue(1'b0, 32'h3000, '0, 4'h0);
    req_write = 1; req_addr = 32'h4000; req_dv = 1;
    tick();
    tick();
    n_checks++;
    if ({awvalid, wvalid, arvalid} !== 3'b001 || araddr !== 32'h3000) begin
      n_fail++;
      $display("FAIL hold_ignore: got aw/w/ar=%b araddr=%h, expected 001 3000", {awvalid, wvalid, arvalid}, araddr);
    end
    req_dv = 0; arready = 1;
    wait_rsp(cyc);
    for (int i = 0; i < 4; i++) tick();
    rvalid = 0;
    n_checks++;
    if (sb.size() != 0 || req_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: got %0d pending hold=%b, expected 0 0", sb.size(), req_hold);
    end
  endtask

  task automatic test_reset_mid();
    arready = 1; rvalid = 0;
    issue(1'b0, 32'h5000, '0, 4'h0);
    tick();
    n_checks++;
    if ({rready, req_hold} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got rready/hold=%b, expected 11", {rready, req_hold});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({arvalid, rready, req_hold, rsp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: got ar/r/hold/rsp=%b, expected 0000", {arvalid, rready, req_hold, rsp_valid});
    end
    rvalid = 1; rdata = 32'hCAFEF00D; rresp = 0; rid = 0; rlast = 1;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (rready !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_r: got rready=%b, expected 0", rready);
    end
    do_txn(1'b0, 32'h6000, '0, 32'hCAFEF00D, 1'b0, 2);
    rvalid = 0;
  endtask

  task automatic test_back_to_back();
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    awready = 1; wready = 1; arready = 1; bvalid = 1; rvalid = 1;
    bresp = 0; rresp = 0; bid = 0; rid = 0; rlast = 1;
    for (int i = 0; i < 8; i++) begin
      wr    = 1'($urandom_range(0, 1));
      a     = $urandom & 32'hFFFF_FFFC;
      d     = $urandom;
      rdata = $urandom;
      do_txn(wr, a, d, wr ? '0 : rdata, 1'b0, 2);
    end
    bvalid = 0; rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_stall();
    test_write_w_first();
    test_errors();
    test_misaligned();
    test_hold_ignore();
    test_reset_mid();
    test_back_to_back();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d outstanding responses, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
